// File: rtl/mips_forward_mem_store_queue_pkg.sv
// Shared types and helpers for the MEM-stage store queue with load forwarding.
package mips_forward_mem_store_queue_pkg;

  localparam int SQ_WORD_WIDTH = 32;
  localparam int SQ_MASK_WIDTH = SQ_WORD_WIDTH / 8;

  typedef logic [SQ_WORD_WIDTH-1:0] sq_word_t;
  typedef logic [SQ_MASK_WIDTH-1:0] sq_mask_t;

  // One queued store: byte address, data and byte enables.
  typedef struct packed {
    sq_word_t addr;
    sq_word_t data;
    sq_mask_t mask;
  } sq_entry_t;

  // Ceiling log2 for elaboration-time sizing of pointers and counters.
  function automatic int sq_clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_forward_mem_store_queue_match.sv
// Byte-granular match of a load against the queued stores. Entries arrive in
// age order (index 0 = oldest), so a later match simply overrides an earlier one.
module mips_forward_mem_store_queue_match #(
  parameter int DEPTH      = 4,
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = WORD_WIDTH / 8
) (
  input  logic [DEPTH-1:0]                 entry_valid,
  input  logic [DEPTH-1:0][WORD_WIDTH-3:0] entry_word,
  input  logic [DEPTH-1:0][WORD_WIDTH-1:0] entry_data,
  input  logic [DEPTH-1:0][MASK_WIDTH-1:0] entry_mask,
  input  logic [WORD_WIDTH-3:0]            ld_word,
  input  logic [MASK_WIDTH-1:0]            ld_mask,
  output logic [MASK_WIDTH-1:0]            supplied,
  output logic [WORD_WIDTH-1:0]            merged
);

  logic [DEPTH-1:0][MASK_WIDTH-1:0] byte_match_s;

  // Per-entry vector of requested bytes that this entry can supply.
  always_comb begin
    byte_match_s = {(DEPTH*MASK_WIDTH){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      byte_match_s[k] = (entry_valid[k] && (entry_word[k] == ld_word))
                        ? (entry_mask[k] & ld_mask) : {MASK_WIDTH{1'b0}};
    end
  end

  // Youngest-wins byte select: walk oldest to youngest, last match sticks.
  always_comb begin
    supplied = {MASK_WIDTH{1'b0}};
    merged   = {WORD_WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        supplied[b]      = supplied[b] | byte_match_s[k][b];
        merged[b*8 +: 8] = byte_match_s[k][b] ? entry_data[k][b*8 +: 8] : merged[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mips_forward_mem_store_queue.sv
// MEM-stage store queue: circular buffer drained to data memory in order, with
// combinational store-to-load forwarding (or stall when forwarding is disabled).
module mips_forward_mem_store_queue
  import mips_forward_mem_store_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DIRECT     = 1,
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = WORD_WIDTH / 8,
  parameter int CNT_W      = sq_clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [WORD_WIDTH-1:0] enq_addr,
  input  logic [WORD_WIDTH-1:0] enq_data,
  input  logic [MASK_WIDTH-1:0] enq_mask,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [WORD_WIDTH-1:0] drain_addr,
  output logic [WORD_WIDTH-1:0] drain_data,
  output logic [MASK_WIDTH-1:0] drain_mask,
  input  logic                  ld_valid,
  input  logic [WORD_WIDTH-1:0] ld_addr,
  input  logic [MASK_WIDTH-1:0] ld_mask,
  output logic                  ld_hit,
  output logic [WORD_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = CNT_W - 1;

  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;
  logic [WORD_WIDTH-1:0] mem_addr_r [DEPTH];
  logic [WORD_WIDTH-1:0] mem_data_r [DEPTH];
  logic [MASK_WIDTH-1:0] mem_mask_r [DEPTH];

  logic                  full_s;
  logic                  empty_s;
  logic                  enq_fire_s;
  logic                  drain_fire_s;
  logic [PTR_W-1:0]      slot_s;
  logic [DEPTH-1:0]                 age_valid_s;
  logic [DEPTH-1:0][WORD_WIDTH-3:0] age_word_s;
  logic [DEPTH-1:0][WORD_WIDTH-1:0] age_data_s;
  logic [DEPTH-1:0][MASK_WIDTH-1:0] age_mask_s;
  logic [MASK_WIDTH-1:0] supplied_s;
  logic [WORD_WIDTH-1:0] merged_s;
  logic                  ld_offset_unused_s;

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign enq_fire_s   = enq_valid && !full_s;
  assign drain_fire_s = !empty_s && drain_ready;

  assign enq_ready   = !full_s;
  assign drain_valid = !empty_s;
  assign full        = full_s;
  assign empty       = empty_s;
  assign count       = count_r;
  assign drain_addr  = mem_addr_r[head_r];
  assign drain_data  = mem_data_r[head_r];
  assign drain_mask  = mem_mask_r[head_r];

  // Byte offset is irrelevant to word-granular forwarding.
  assign ld_offset_unused_s = ^ld_addr[1:0];

  // Pointer and occupancy state; reset discards every queued entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (enq_fire_s) begin
        tail_r <= tail_r + PTR_W'(1'b1);
      end
      if (drain_fire_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      case ({enq_fire_s, drain_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage is written at the tail; contents need no reset.
  always_ff @(posedge clock) begin
    if (enq_fire_s) begin
      mem_addr_r[tail_r] <= enq_addr;
      mem_data_r[tail_r] <= enq_data;
      mem_mask_r[tail_r] <= enq_mask;
    end
  end

  // Rotate storage into age order; validity comes from head and occupancy only.
  always_comb begin
    slot_s      = {PTR_W{1'b0}};
    age_valid_s = {DEPTH{1'b0}};
    age_word_s  = {(DEPTH*(WORD_WIDTH-2)){1'b0}};
    age_data_s  = {(DEPTH*WORD_WIDTH){1'b0}};
    age_mask_s  = {(DEPTH*MASK_WIDTH){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      slot_s         = head_r + PTR_W'(k);
      age_valid_s[k] = (CNT_W'(k) < count_r);
      age_word_s[k]  = mem_addr_r[slot_s][WORD_WIDTH-1:2];
      age_data_s[k]  = mem_data_r[slot_s];
      age_mask_s[k]  = mem_mask_r[slot_s];
    end
  end

  mips_forward_mem_store_queue_match #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (WORD_WIDTH),
    .MASK_WIDTH (MASK_WIDTH)
  ) u_match (
    .entry_valid (age_valid_s),
    .entry_word  (age_word_s),
    .entry_data  (age_data_s),
    .entry_mask  (age_mask_s),
    .ld_word     (ld_addr[WORD_WIDTH-1:2]),
    .ld_mask     (ld_mask),
    .supplied    (supplied_s),
    .merged      (merged_s)
  );

  // Load resolution: full cover forwards, partial cover (or any cover without forwarding) stalls.
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = {WORD_WIDTH{1'b0}};
    if (!ld_valid || (ld_mask == {MASK_WIDTH{1'b0}}) || (supplied_s == {MASK_WIDTH{1'b0}})) begin
      ld_hit = 1'b0;
    end else if ((DIRECT != 0) && (supplied_s == ld_mask)) begin
      ld_hit  = 1'b1;
      ld_data = merged_s;
    end else begin
      ld_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_forward_mem_store_queue.sv
// Directed plus randomized bench; a queue-based model predicts occupancy, head
// contents and forwarding for both the forwarding and the stall-only variant.
module tb_mips_forward_mem_store_queue;
  import mips_forward_mem_store_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_mask;
  logic        drain_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_mask;

  logic        enq_ready, drain_valid, ld_hit, ld_stall, full, empty;
  logic [31:0] drain_addr, drain_data, ld_data;
  logic [3:0]  drain_mask;
  logic [2:0]  count;

  logic        enq_ready0, drain_valid0, ld_hit0, ld_stall0, full0, empty0;
  logic [31:0] drain_addr0, drain_data0, ld_data0;
  logic [3:0]  drain_mask0;
  logic [2:0]  count0;

  int vectors = 0;
  int miscompares = 0;
  int n_checks = 0;

  sq_entry_t q[$];

  mips_forward_mem_store_queue #(.DEPTH(DEPTH), .DIRECT(1), .WORD_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data), .enq_mask(enq_mask),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_addr(drain_addr), .drain_data(drain_data), .drain_mask(drain_mask),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .count(count), .full(full), .empty(empty)
  );

  mips_forward_mem_store_queue #(.DEPTH(DEPTH), .DIRECT(0), .WORD_WIDTH(32)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready0),
    .enq_addr(enq_addr), .enq_data(enq_data), .enq_mask(enq_mask),
    .drain_valid(drain_valid0), .drain_ready(drain_ready),
    .drain_addr(drain_addr0), .drain_data(drain_data0), .drain_mask(drain_mask0),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask),
    .ld_hit(ld_hit0), .ld_data(ld_data0), .ld_stall(ld_stall0),
    .count(count0), .full(full0), .empty(empty0)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: per requested byte, youngest queued store covering it.
  task automatic ref_load(input bit lv, input logic [31:0] la, input logic [3:0] lm,
                          input bit direct, output logic eh, output logic es,
                          output logic [31:0] ed);
    logic [3:0]  sup;
    logic [31:0] md;
    sup = 4'b0000;
    md  = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (lm[b]) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr[31:2] == la[31:2] && q[i].mask[b]) begin
            sup[b]     = 1'b1;
            md[8*b+:8] = q[i].data[8*b+:8];
            break;
          end
        end
      end
    end
    eh = 1'b0;
    es = 1'b0;
    ed = 32'h0;
    if (lv && lm != 4'b0000 && sup != 4'b0000) begin
      if (direct && sup == lm) begin
        eh = 1'b1;
        ed = md;
      end else begin
        es = 1'b1;
      end
    end
  endtask

  // Apply one cycle's inputs and check every observable against the model.
  task automatic drive(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] em, input bit dr, input bit lv,
                       input logic [31:0] la, input logic [3:0] lm);
    logic        eh, es;
    logic [31:0] edat;
    enq_valid = ev; enq_addr = ea; enq_data = ed; enq_mask = em;
    drain_ready = dr; ld_valid = lv; ld_addr = la; ld_mask = lm;
    #3;
    chk("count", {29'd0, count}, q.size());
    chk("count0", {29'd0, count0}, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("enq_ready", enq_ready, q.size() < DEPTH);
    chk("drain_valid", drain_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("drain_addr", drain_addr, q[0].addr);
      chk("drain_data", drain_data, q[0].data);
      chk("drain_mask", {28'd0, drain_mask}, {28'd0, q[0].mask});
    end
    ref_load(lv, la, lm, 1'b1, eh, es, edat);
    chk("ld_hit", ld_hit, eh);
    chk("ld_stall", ld_stall, es);
    chk("ld_data", ld_data, edat);
    ref_load(lv, la, lm, 1'b0, eh, es, edat);
    chk("ld_hit0", ld_hit0, eh);
    chk("ld_stall0", ld_stall0, es);
    chk("ld_data0", ld_data0, edat);
  endtask

  // Clock edge: update the model with whatever handshakes were open.
  task automatic tick();
    bit ef, df;
    sq_entry_t e;
    ef = enq_valid && (q.size() < DEPTH);
    df = drain_ready && (q.size() > 0);
    e.addr = enq_addr; e.data = enq_data; e.mask = enq_mask;
    @(posedge clock);
    if (df) q.delete(0);
    if (ef) q.push_back(e);
    #1;
    vectors++;
  endtask

  task automatic cycle(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] em, input bit dr, input bit lv,
                       input logic [31:0] la, input logic [3:0] lm);
    drive(ev, ea, ed, em, dr, lv, la, lm);
    tick();
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0);
    end
    chk("drained", q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    enq_valid = 1'b0; enq_addr = 32'h0; enq_data = 32'h0; enq_mask = 4'h0;
    drain_ready = 1'b0; ld_valid = 1'b1; ld_addr = 32'h100; ld_mask = 4'hF;
    #2;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_enq_ready", enq_ready, 1'b1);
    chk("rst_drain_valid", drain_valid, 1'b0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_ld_stall", ld_stall, 1'b0);
    #6 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fill to full, then a refused fifth store.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, 1'b1, 32'h104, 4'hF);
    end
    drive(1'b1, 32'h110, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("fill_full", full, 1'b1);
    chk("fill_enq_ready", enq_ready, 1'b0);
    chk("fill_count", {29'd0, count}, 32'd4);
    tick();
    chk("fill_no_5th", {29'd0, count}, 32'd4);

    // Full with drain: drain fires, enqueue refused; next cycle accepted.
    drive(1'b1, 32'h110, 32'h0000_0110, 4'hF, 1'b1, 1'b0, 32'h0, 4'h0);
    tick();
    chk("wrap_after_drain", {29'd0, count}, 32'd3);
    cycle(1'b1, 32'h110, 32'h0000_0110, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h700 + 32'(4 * i), 32'h7000_0000 + 32'(i), 4'hF, 1'b1,
            1'b1, 32'h700 + 32'(4 * (i - 1)), 4'hF);
    end
    drain_all();

    // Youngest store wins per byte.
    cycle(1'b1, 32'h200, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0);
    cycle(1'b1, 32'h200, 32'h0000_00AA, 4'h1, 1'b0, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h200, 4'hF);
    chk("young_hit", ld_hit, 1'b1);
    chk("young_data", ld_data, 32'h1111_11AA);
    chk("young_stall0", ld_stall0, 1'b1);
    tick();
    drain_all();

    // Partial coverage stalls, including while the head is being drained.
    cycle(1'b1, 32'h300, 32'h0000_5566, 4'h3, 1'b0, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300, 4'hF);
    chk("partial_stall", ld_stall, 1'b1);
    chk("partial_hit", ld_hit, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h300, 4'hF);
    chk("post_drain_stall", ld_stall, 1'b0);
    chk("post_drain_hit", ld_hit, 1'b0);
    tick();

    // Forwarding disabled: any overlap stalls.
    cycle(1'b1, 32'h400, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h400, 4'h1);
    chk("nofwd_stall0", ld_stall0, 1'b1);
    chk("nofwd_hit0", ld_hit0, 1'b0);
    chk("fwd_data", ld_data, 32'h0000_0078);
    tick();
    drain_all();

    // Randomized traffic on a small address window to force overlaps.
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)),
            32'h500 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)),
            32'h500 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end
    drain_all();

    // Asynchronous reset with three undrained entries and a stalled head.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h600 + 32'(4 * i), 32'h6000_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, 4'h0);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("async_empty", empty, 1'b1);
    chk("async_drain_valid", drain_valid, 1'b0);
    chk("async_count", {29'd0, count}, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h604, 4'hF);
    chk("post_rst_hit", ld_hit, 1'b0);
    chk("post_rst_stall", ld_stall, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
